pipeline_if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a decoupled instruction-memory request/response interface, an in-order prefetch FIFO, branch redirect with flush, and load-use hazard bubbling toward ID. Sits between the instruction memory port and the ID stage. Takes redirects from EX and replaces the fixed-ROM, single-cycle fetch stage.

---
 rtl/pipeline_pkg.sv | 36 +++
 rtl/if_fetch_fifo.sv | 66 ++++++
 rtl/pipeline_if_prefetch.sv | 153 +++++++++++++++
 tb/tb_pipeline_if_prefetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared opcode constants, fetch-entry layout and small decode
//               helpers for the pipeline front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  // Major opcode field, instr[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;

  // Prefetch entry layout for the default 32-bit PC; the fetch stage packs
  // the same {pc, instr} order into an XLEN-wide vector.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_load(input logic [31:0] instr);
    return instr[6:2] == OPC_LOAD;
  endfunction

  // Formats whose rs2 field is a real source register
  function automatic logic uses_rs2(input logic [31:0] instr);
    return (instr[6:2] == OPC_BRANCH) || (instr[6:2] == OPC_OP) ||
           (instr[6:2] == OPC_STORE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_fifo.sv
// ============================================================================
// Module      : if_fetch_fifo
// Description : Show-ahead synchronous FIFO with occupancy count and a flush
//               that empties it in one cycle (flush beats push and pop).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i & (count_q != (AW+1)'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q  <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_if_prefetch.sv
// ============================================================================
// Module      : pipeline_if_prefetch
// Description : Instruction-fetch stage with decoupled imem req/rsp port,
//               credit-limited in-order prefetch FIFO, branch redirect with
//               flush/discard, and optional load-use bubble toward ID.
//               Optional feature macro: IF_LOAD_USE_DETECT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_if_prefetch
  import pipeline_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic            stall_load_o
);

  localparam int unsigned     CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned     DW      = XLEN + 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;   // PC of the next kept response
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [DW-1:0]   fifo_head;
  logic [CW:0]     used;
  logic            accept;
  logic            drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_pc;

  // Outstanding requests plus stored entries may never exceed the FIFO, so
  // every response is guaranteed a slot.
  assign used        = {1'b0, outst_q} + {1'b0, fifo_count};
  assign imem_req_o  = run_q & ~branch_i & (used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign accept      = imem_req_o & imem_gnt_i;
  assign drop        = imem_rvalid_i & (branch_i | (discard_q != '0));
  assign push        = imem_rvalid_i & ~drop;
  assign pop         = id_valid_o & id_ready_i;
  assign target_pc   = branch_pc_i & ~XLEN'(3);

  assign id_pc_o     = fifo_head[DW-1:32];
  assign id_instr_o  = fifo_head[31:0];

  // Next-state for PCs and in-flight/discard counters; a branch overrides all
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(accept) - CW'(imem_rvalid_i);
    discard_d  = discard_q;
    if (branch_i) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      discard_d  = outst_q - CW'(imem_rvalid_i);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push)   resp_pc_d  = resp_pc_q + PC_STEP;
      if (drop)   discard_d  = discard_q - CW'(1);
    end
  end

  // Fetch-side state registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  if_fetch_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (branch_i),
    .push_i      (push),
    .push_data_i ({resp_pc_q, imem_rdata_i}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

`ifdef IF_LOAD_USE_DETECT_EN
  logic       ld_pend_q;
  logic [4:0] ld_rd_q;
  logic       hazard;

  // Head consumer reads the pending load's destination via rs1 or rs2
  always_comb begin
    hazard = 1'b0;
    if (ld_pend_q && !fifo_empty) begin
      hazard = (id_instr_o[19:15] == ld_rd_q) ||
               (uses_rs2(id_instr_o) && (id_instr_o[24:20] == ld_rd_q));
    end
  end

  assign id_valid_o   = ~fifo_empty & ~hazard;
  assign stall_load_o = hazard;

  // Track the most recently issued load; a hazard costs exactly one bubble
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ld_pend_q <= 1'b0;
      ld_rd_q   <= '0;
    end else if (branch_i || hazard) begin
      ld_pend_q <= 1'b0;
    end else if (pop) begin
      ld_pend_q <= is_load(id_instr_o) && (id_instr_o[11:7] != 5'd0);
      ld_rd_q   <= id_instr_o[11:7];
    end
  end
`else
  assign id_valid_o   = ~fifo_empty;
  assign stall_load_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_if_prefetch.sv
// ============================================================================
// Module      : tb_pipeline_if_prefetch
// Description : Directed self-checking bench for pipeline_if_prefetch with a
//               behavioural instruction memory of configurable latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipeline_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [31:0] branch_pc;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        stall;

  always #5 clk = ~clk;

  pipeline_if_prefetch #(
    .XLEN       (32),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .branch_i      (branch),
    .branch_pc_i   (branch_pc),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_ready),
    .id_instr_o    (id_instr),
    .id_pc_o       (id_pc),
    .stall_load_o  (stall)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   = 1;
  int n_acc, n_rsp, max_out, n_stall;

  logic [31:0] aq_addr[$];
  int          aq_rdy[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  int          pop_cyc[$];
  logic [31:0] prog   [16];
  logic        prog_v [16];

  // Memory image: small program overlay, otherwise addi x0,x0,<addr>
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a < 32'd64 && prog_v[a[5:2]]) return prog[a[5:2]];
    return 32'h0000_0013 | {a[11:0], 20'h0};
  endfunction

  // Memory responder and ID-side monitor; samples 1 ns before each rising edge
  initial begin
    logic s_req, s_gnt, s_rv, s_pop, s_stall, s_rst;
    logic [31:0] s_addr, s_pc, s_instr;
    rvalid = 1'b0;
    rdata  = '0;
    n_acc = 0; n_rsp = 0; max_out = 0; n_stall = 0;
    forever begin
      @(negedge clk); #4;
      s_req = req; s_gnt = gnt; s_rv = rvalid; s_addr = addr;
      s_pop = id_valid & id_ready; s_pc = id_pc; s_instr = id_instr;
      s_stall = stall; s_rst = rst;
      @(posedge clk);
      cyc++;
      #1;
      if (s_rst) begin
        aq_addr.delete(); aq_rdy.delete();
        pop_pc.delete(); pop_instr.delete(); pop_cyc.delete();
        n_acc = 0; n_rsp = 0; max_out = 0; n_stall = 0;
        rvalid = 1'b0;
      end else begin
        if (s_rv) n_rsp++;
        if (s_req && s_gnt) begin
          aq_addr.push_back(s_addr);
          aq_rdy.push_back(cyc + lat - 1);
          n_acc++;
        end
        if (n_acc - n_rsp > max_out) max_out = n_acc - n_rsp;
        if (s_pop) begin
          pop_pc.push_back(s_pc);
          pop_instr.push_back(s_instr);
          pop_cyc.push_back(cyc);
        end
        if (s_stall) n_stall++;
        if (aq_addr.size() > 0 && aq_rdy[0] <= cyc) begin
          rvalid = 1'b1;
          rdata  = instr_at(aq_addr.pop_front());
          void'(aq_rdy.pop_front());
        end else begin
          rvalid = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1);
  end

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      prog[i]   = '0;
      prog_v[i] = 1'b0;
    end
  endtask

  task automatic do_reset(input int l);
    @(negedge clk);
    rst = 1'b1; lat = l; branch = 1'b0; branch_pc = '0;
    id_ready = 1'b1; gnt = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; lat = 1; branch = 1'b0; branch_pc = '0; id_ready = 1'b1; gnt = 1'b1;
    #1;
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", req); end
    tests++; if (addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", addr); end
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", stall); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL rel_req: got %b want 0", req); end
    @(negedge clk);
    tests++; if (req !== 1'b1) begin fails++; $display("FAIL first_req: got %b want 1", req); end
    tests++; if (addr !== 32'h0) begin fails++; $display("FAIL first_addr: got %h want 0", addr); end
  endtask

  task automatic check_order(input string nm, input logic [31:0] base, input int min_n);
    tests++;
    if (pop_pc.size() < min_n) begin
      fails++; $display("FAIL %s_count: got %0d pops want >=%0d", nm, pop_pc.size(), min_n);
    end
    for (int i = 0; i < pop_pc.size(); i++) begin
      tests++;
      if (pop_pc[i] !== base + 32'(4*i) || pop_instr[i] !== instr_at(base + 32'(4*i))) begin
        fails++;
        $display("FAIL %s_pop%0d: got pc=%h instr=%h want pc=%h instr=%h", nm, i,
                 pop_pc[i], pop_instr[i], base + 32'(4*i), instr_at(base + 32'(4*i)));
      end
    end
  endtask

  task automatic test_stream();
    clear_prog();
    do_reset(1);
    repeat (25) @(negedge clk);
    check_order("stream", 32'h0, 15);
    for (int i = 1; i < pop_cyc.size(); i++) begin
      tests++;
      if (pop_cyc[i] !== pop_cyc[i-1] + 1) begin
        fails++; $display("FAIL stream_gap%0d: got cycle %0d want %0d", i, pop_cyc[i], pop_cyc[i-1] + 1);
      end
    end
    tests++; if (n_stall !== 0) begin fails++; $display("FAIL stream_stall: got %0d want 0", n_stall); end
  endtask

  task automatic test_latency3();
    clear_prog();
    do_reset(3);
    repeat (40) @(negedge clk);
    check_order("lat3", 32'h0, 10);
    tests++; if (max_out > 4) begin fails++; $display("FAIL lat3_outstanding: got %0d want <=4", max_out); end
  endtask

  task automatic test_branch();
    int w;
    clear_prog();
    do_reset(3);
    w = 0;
    while (n_acc < 2 && w < 20) begin @(negedge clk); w++; end
    tests++;
    if (n_acc !== 2 || n_rsp !== 0) begin
      fails++; $display("FAIL br_setup: got acc=%0d rsp=%0d want acc=2 rsp=0", n_acc, n_rsp);
    end
    branch = 1'b1; branch_pc = 32'h103;
    #1;
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL br_req: got %b want 0", req); end
    @(negedge clk);
    branch = 1'b0;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL br_empty: got %b want 0", id_valid); end
    tests++; if (addr !== 32'h100) begin fails++; $display("FAIL br_addr: got %h want 100", addr); end
    repeat (20) @(negedge clk);
    check_order("br", 32'h100, 4);
  endtask

  task automatic test_backpressure();
    clear_prog();
    do_reset(1);
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 5) begin
        tests++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
          fails++; $display("FAIL hold_head%0d: got valid=%b pc=%h want valid=1 pc=0", i, id_valid, id_pc);
        end
      end
    end
    tests++; if (n_acc !== 4) begin fails++; $display("FAIL hold_acc: got %0d want 4", n_acc); end
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL hold_req: got %b want 0", req); end
    tests++; if (id_instr !== instr_at(32'h0)) begin fails++; $display("FAIL hold_instr: got %h want %h", id_instr, instr_at(32'h0)); end
    id_ready = 1'b1;
    repeat (20) @(negedge clk);
    check_order("resume", 32'h0, 12);
  endtask

  // lw at 0 followed by a consumer at 4; checks the gap between their pops
  task automatic run_pair(input string nm, input logic [31:0] i0, input logic [31:0] i1,
                          input int want_gap, input int want_stall);
    clear_prog();
    prog[0] = i0; prog_v[0] = 1'b1;
    prog[1] = i1; prog_v[1] = 1'b1;
    do_reset(1);
    repeat (15) @(negedge clk);
    check_order(nm, 32'h0, 4);
    if (pop_cyc.size() >= 2) begin
      tests++;
      if (pop_cyc[1] - pop_cyc[0] !== want_gap) begin
        fails++; $display("FAIL %s_gap: got %0d want %0d", nm, pop_cyc[1] - pop_cyc[0], want_gap);
      end
    end
    tests++; if (n_stall !== want_stall) begin fails++; $display("FAIL %s_stall: got %0d want %0d", nm, n_stall, want_stall); end
  endtask

`ifdef IF_LOAD_USE_DETECT_EN
  task automatic test_load_use();
    run_pair("lu_add",  32'h0000_2283, 32'h0012_8333, 2, 1);  // lw x5 ; add x6,x5,x1
    run_pair("lu_x0",   32'h0000_2003, 32'h0010_0333, 1, 0);  // lw x0 ; add x6,x0,x1
    run_pair("lu_sw",   32'h0000_2283, 32'h0050_A023, 2, 1);  // lw x5 ; sw x5,0(x1)
  endtask
`else
  task automatic test_load_use();
    run_pair("nolu_sw",  32'h0000_2283, 32'h0050_A023, 1, 0); // lw x5 ; sw x5,0(x1)
    run_pair("nolu_add", 32'h0000_2283, 32'h0012_8333, 1, 0); // lw x5 ; add x6,x5,x1
  endtask
`endif

  initial begin
    rst = 1'b1; branch = 1'b0; branch_pc = '0; gnt = 1'b1; id_ready = 1'b1;
    clear_prog();
    test_reset();
    test_stream();
    test_latency3();
    test_branch();
    test_backpressure();
    test_load_use();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
